// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared constants for the instruction-fetch front end.
//   XLEN / ILEN      : address and instruction widths
//   PC_STEP          : byte distance between sequential instruction words
//   RESET_PC_DEFAULT : default first fetch address after reset
//   NOP_INST         : canonical no-op encoding (addi x0, x0, 0)
//   align_pc()       : forces a byte address onto a word boundary
package ifetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [ILEN-1:0] NOP_INST         = 32'h0000_0013;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~(XLEN'(3));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered storage.
//   clk, rst : clock and synchronous active-high reset (pointers/count only)
//   push/din : write din at the tail
//   pop      : drop the head entry (ignored while empty)
//   flush    : empty the FIFO; wins over push and pop in the same cycle
//   dout     : current head entry (meaningless while count == 0)
//   count    : number of occupied entries, 0..DEPTH
module sync_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  input  logic              flush,
  output logic [DATA_W-1:0] dout,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              pop_en;

  assign pop_en = pop && (count != '0);
  assign dout   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Storage carries no reset; stale contents are masked by count.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= din;
  end

  // The producer reserves space before asking for data, so a push into a
  // full FIFO means the reservation logic upstream is broken.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(push && !pop_en && count == CNT_W'(DEPTH)))
        else $error("sync_fifo overflow");
    end
  end

endmodule

// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch: sequential instruction prefetcher feeding the core.
//   clk, rst                      : clock, synchronous active-high reset
//   mem_req_valid/ready/addr      : word fetch requests to instruction memory
//   mem_rsp_valid/data            : in-order responses, no backpressure
//   inst_valid/ready, inst/inst_pc: buffered instruction handed to the core
//   redirect, redirect_pc         : core-initiated change of fetch stream
// Requests are only issued while a FIFO slot is reserved for the answer
// (outstanding + buffered < DEPTH). On redirect every request still in
// flight becomes stale and is counted into drop_cnt; no new request goes
// out until all stale responses have drained.
module ifetch_prefetch
  import ifetch_pkg::*;
#(
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [ILEN-1:0] mem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SUM_W = CNT_W + 1;

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  head_pc;
  logic [XLEN-1:0]  redirect_target;
  logic [OUT_W-1:0] outstanding;
  logic [OUT_W-1:0] outstanding_next;
  logic [OUT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] fifo_count;
  logic [SUM_W-1:0] reserved;
  logic             req_acc;
  logic             rsp_keep;
  logic             pop;

  assign redirect_target = align_pc(redirect_pc);
  assign reserved        = SUM_W'(outstanding) + SUM_W'(fifo_count);

  // Every term only loosens through an accept, so a raised request holds
  // its value until taken unless redirect or rst withdraws it.
  assign mem_req_valid = !rst && !redirect && (drop_cnt == '0)
                      && (outstanding < OUT_W'(MAX_OUTSTANDING))
                      && (reserved < SUM_W'(DEPTH));
  assign mem_req_addr  = fetch_pc;
  assign req_acc       = mem_req_valid && mem_req_ready;

  // A response arriving alongside a redirect belongs to the old stream.
  assign rsp_keep   = mem_rsp_valid && (drop_cnt == '0) && !redirect;
  assign inst_valid = (fifo_count != '0);
  assign inst_pc    = head_pc;
  assign pop        = inst_valid && inst_ready && !redirect;

  always_comb begin
    outstanding_next = outstanding;
    case ({req_acc, mem_rsp_valid})
      2'b10:   outstanding_next = outstanding + OUT_W'(1);
      2'b01:   outstanding_next = outstanding - OUT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      head_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect) begin
        fetch_pc <= redirect_target;
        head_pc  <= redirect_target;
        // Replaces any earlier drop count: everything still unanswered
        // after this edge is stale, including an older stale backlog.
        drop_cnt <= outstanding_next;
      end else begin
        if (req_acc) fetch_pc <= fetch_pc + PC_STEP;
        if (pop)     head_pc  <= head_pc + PC_STEP;
        if (mem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - OUT_W'(1);
      end
    end
  end

  sync_fifo #(
    .DATA_W (ILEN),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_keep),
    .din   (mem_rsp_data),
    .pop   (pop),
    .flush (redirect),
    .dout  (inst),
    .count (fifo_count)
  );

endmodule
